// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS encodings, instruction field ranges and writeback extension ops
package mips_pkg;
  localparam int OP_HI = 31, OP_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int SH_HI = 10, SH_LO = 6;
  localparam int FN_HI = 5, FN_LO = 0;
  localparam int IMM_HI = 15, IMM_LO = 0;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_JAL = 6'h03;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JALR = 6'h09, F_MFHI = 6'h10, F_MFLO = 6'h12;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2a, F_SLTU = 6'h2b;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] LINK_REG = 5'd31;
  typedef enum logic [2:0] {
    EXT_WORD = 3'b000,
    EXT_LHU  = 3'b001,
    EXT_LBU  = 3'b010,
    EXT_LH   = 3'b101,
    EXT_LB   = 3'b110
  } ext_op_e;
endpackage

// File: rtl/wb_load_ext.sv
// wb_load_ext: selects and extends the byte/halfword of a little-endian load word
module wb_load_ext
  import mips_pkg::*;
(
  input  ext_op_e     ext_op,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{addr, 3'b000} +: 8];
    h = addr[1] ? word[31:16] : word[15:0];
    data = ext_op == EXT_LB  ? {{24{b[7]}}, b} :
           ext_op == EXT_LBU ? {24'h0, b} :
           ext_op == EXT_LH  ? {{16{h[15]}}, h} :
           ext_op == EXT_LHU ? {16'h0, h} : word;
  end
endmodule

// File: rtl/mw_writeback_stage.sv
// mw_writeback_stage: M/W pipeline register, writeback decode and register-file write port
// `WB_RETIRE_CNT_EN adds the retired-instruction counter and its retire_cnt port
module mw_writeback_stage
  import mips_pkg::*;
`ifdef WB_RETIRE_CNT_EN
  #(parameter int RETIRE_CNT_W = 32)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        valid_M,
  input  logic [31:0] instr_M,
  input  logic [31:0] pc8_M,
  input  logic [31:0] alu_out_M,
  input  logic [31:0] dm_out_M,
  output logic        valid_W,
  output logic [31:0] instr_W,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [4:0]  fwd_addr_W,
  output logic [31:0] fwd_data_W
`ifdef WB_RETIRE_CNT_EN
  , output logic [RETIRE_CNT_W-1:0] retire_cnt
`endif
);
  logic [31:0] pc8_W, alu_W, dm_W, ext_data;
  logic [5:0]  op, funct;
  logic [4:0]  rt, rd, dest;
  logic        load, r_rd, imm, link31, link;
  ext_op_e     ext_op;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {valid_W, instr_W, pc8_W, alu_W, dm_W} <= '0;
    else if (flush_i) {valid_W, instr_W, pc8_W, alu_W, dm_W} <= '0;
    else if (!stall_i) {valid_W, instr_W, pc8_W, alu_W, dm_W} <= {valid_M, instr_M, pc8_M, alu_out_M, dm_out_M};
  always_comb begin
    op = instr_W[OP_HI:OP_LO];
    funct = instr_W[FN_HI:FN_LO];
    rt = instr_W[RT_HI:RT_LO];
    rd = instr_W[RD_HI:RD_LO];
    load = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    r_rd = op == OP_RTYPE && funct inside {F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_JALR, F_MFHI, F_MFLO,
                                           F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU};
    imm = op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
    link31 = op == OP_JAL || (op == OP_REGIMM && rt == RT_BLTZAL);
    link = link31 || (op == OP_RTYPE && funct == F_JALR);
    dest = link31 ? LINK_REG : r_rd ? rd : rt;
    rf_we = valid_W && (load || r_rd || imm || link31) && dest != 5'd0;
    rf_waddr = dest;
    fwd_addr_W = rf_we ? dest : 5'd0;
    ext_op = op == OP_LB  ? EXT_LB :
             op == OP_LBU ? EXT_LBU :
             op == OP_LH  ? EXT_LH :
             op == OP_LHU ? EXT_LHU : EXT_WORD;
    rf_wdata = link ? pc8_W : load ? ext_data : alu_W;
    fwd_data_W = rf_wdata;
  end
  wb_load_ext u_ext (
    .ext_op (ext_op),
    .addr   (alu_W[1:0]),
    .word   (dm_W),
    .data   (ext_data)
  );
`ifdef WB_RETIRE_CNT_EN
  // counts instructions as they leave W, so a stalled instruction is counted once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) retire_cnt <= '0;
    else if (valid_W && !stall_i) retire_cnt <= retire_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_mw_writeback_stage.sv
// tb_mw_writeback_stage: directed and random checks of the writeback stage against a spec-level model
module tb_mw_writeback_stage;
  logic clk = 1'b0, rst_n = 1'b0, stall_i = 1'b0, flush_i = 1'b0, valid_M = 1'b0;
  logic [31:0] instr_M = '0, pc8_M = '0, alu_out_M = '0, dm_out_M = '0;
  logic valid_W, rf_we;
  logic [31:0] instr_W, rf_wdata, fwd_data_W;
  logic [4:0] rf_waddr, fwd_addr_W;
  int total = 0, bad = 0;
  typedef struct packed {logic v; logic [31:0] i, p, a, d;} mw_t;
  typedef struct packed {logic we; logic [4:0] wa; logic [31:0] wd;} wb_t;
  mw_t m = '0;
`ifdef WB_RETIRE_CNT_EN
  logic [3:0] retire_cnt, cnt_m = '0;
  mw_writeback_stage #(.RETIRE_CNT_W(4)) dut (
`else
  mw_writeback_stage dut (
`endif
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .valid_M(valid_M),
    .instr_M(instr_M), .pc8_M(pc8_M), .alu_out_M(alu_out_M), .dm_out_M(dm_out_M),
    .valid_W(valid_W), .instr_W(instr_W), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .fwd_addr_W(fwd_addr_W), .fwd_data_W(fwd_data_W)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );
  always #5 clk = ~clk;

  function automatic wb_t ref_wb(input mw_t r);
    logic [5:0] op, fn;
    logic [4:0] rt, rd;
    logic [7:0] bv;
    logic [15:0] hv;
    int kind;
    wb_t o;
    op = r.i[31:26]; fn = r.i[5:0]; rt = r.i[20:16]; rd = r.i[15:11];
    kind = 0;
    if (op == 0 && fn inside {0, 2, 3, 4, 6, 7, 'h10, 'h12, ['h20:'h27], 'h2a, 'h2b}) kind = 1;
    if (op == 0 && fn == 9) kind = 5;
    if (op inside {['h08:'h0f]}) kind = 2;
    if (op inside {'h20, 'h21, 'h23, 'h24, 'h25}) kind = 3;
    if (op == 3 || (op == 1 && rt == 'h10)) kind = 4;
    o.wa = kind == 4 ? 5'd31 : (kind == 1 || kind == 5) ? rd : rt;
    o.we = r.v && kind != 0 && o.wa != 0;
    bv = 8'(r.d >> (8 * r.a[1:0]));
    hv = 16'(r.d >> (16 * r.a[1]));
    o.wd = (kind == 4 || kind == 5) ? r.p :
           kind == 3 ? (op == 'h20 ? {{24{bv[7]}}, bv} : op == 'h24 ? {24'h0, bv} :
                        op == 'h21 ? {{16{hv[15]}}, hv} : op == 'h25 ? {16'h0, hv} : r.d) : r.a;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    wb_t e;
    e = ref_wb(m);
    chk("valid_W", 32'(valid_W), 32'(m.v));
    chk("instr_W", instr_W, m.i);
    chk("rf_we", 32'(rf_we), 32'(e.we));
    if (e.we) chk("rf_waddr", 32'(rf_waddr), 32'(e.wa));
    chk("rf_wdata", rf_wdata, e.wd);
    chk("fwd_addr_W", 32'(fwd_addr_W), e.we ? 32'(e.wa) : 32'd0);
    chk("fwd_data_W", fwd_data_W, e.wd);
`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt", 32'(retire_cnt), 32'(cnt_m));
`endif
  endtask

  task automatic drive(input logic v, input logic [31:0] i, p, a, d, input logic st, fl);
    valid_M = v; instr_M = i; pc8_M = p; alu_out_M = a; dm_out_M = d; stall_i = st; flush_i = fl;
  endtask

  task automatic step();
    @(posedge clk);
`ifdef WB_RETIRE_CNT_EN
    if (m.v && !stall_i) cnt_m++;
`endif
    if (flush_i) m = '0;
    else if (!stall_i) m = '{valid_M, instr_M, pc8_M, alu_out_M, dm_out_M};
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m = '0;
`ifdef WB_RETIRE_CNT_EN
    cnt_m = '0;
`endif
    check_all();
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_wdata", rf_wdata, 0);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops[18] = '{0, 0, 0, 1, 2, 3, 4, 8, 9, 'h0a, 'h0c, 'h0d, 'h0f, 'h20, 'h21, 'h23, 'h24, 'h2b};
    logic [5:0] fns[14] = '{0, 2, 7, 8, 9, 'h10, 'h12, 'h18, 'h20, 'h21, 'h27, 'h28, 'h2a, 'h2b};
    logic [4:0] rts[4] = '{0, 1, 'h10, 'h11};
    logic [31:0] w;
    w = $urandom;
    w[31:26] = ($urandom_range(0, 15) == 0) ? 6'h3f : ops[$urandom_range(0, 17)];
    if (w[31:26] == 0) w[5:0] = fns[$urandom_range(0, 13)];
    if (w[31:26] == 1) w[20:16] = rts[$urandom_range(0, 3)];
    if ($urandom_range(0, 7) == 0) w[20:11] = '0;
    return w;
  endfunction

  localparam logic [31:0] DM = 32'h80FF_1234;
  localparam logic [31:0] ADDI5 = {6'h08, 5'd0, 5'd5, 16'h0007};

  initial begin
    #7;
    check_all();
    rst_n = 1'b1;
    drive(1, {6'h20, 5'd0, 5'd3, 16'h0}, 0, 32'h1003, DM, 0, 0); step();
    chk("lb", rf_wdata, 32'hFFFF_FF80);
    chk("lb_addr", 32'(rf_waddr), 3);
    drive(1, {6'h24, 5'd0, 5'd3, 16'h0}, 0, 32'h1003, DM, 0, 0); step();
    chk("lbu", rf_wdata, 32'h0000_0080);
    drive(1, {6'h21, 5'd0, 5'd4, 16'h0}, 0, 32'h1002, DM, 0, 0); step();
    chk("lh", rf_wdata, 32'hFFFF_80FF);
    drive(1, {6'h25, 5'd0, 5'd4, 16'h0}, 0, 32'h1000, DM, 0, 0); step();
    chk("lhu", rf_wdata, 32'h0000_1234);
    drive(1, {6'h03, 26'h123}, 32'h0000_3008, 32'hDEAD_BEEF, DM, 0, 0); step();
    chk("jal_addr", 32'(rf_waddr), 31);
    chk("jal_data", rf_wdata, 32'h0000_3008);
    chk("jal_we", 32'(rf_we), 1);
    drive(1, {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h21}, 0, 32'h55, DM, 0, 0); step();
    chk("addu0_we", 32'(rf_we), 0);
    chk("addu0_fwd", 32'(fwd_addr_W), 0);
    drive(1, ADDI5, 0, 32'd7, 0, 0, 0); step();
    for (int k = 0; k < 3; k++) begin
      drive(1, rand_instr(), $urandom, $urandom, $urandom, 1, 0); step();
      chk("stall_instr", instr_W, ADDI5);
      chk("stall_we", 32'(rf_we), 1);
      chk("stall_data", rf_wdata, 7);
    end
    drive(1, rand_instr(), $urandom, $urandom, $urandom, 1, 1); step();
    chk("flush_valid", 32'(valid_W), 0);
    chk("flush_we", 32'(rf_we), 0);
    drive(1, {6'h03, 26'h0}, 32'h40, 0, 0, 0, 0); step();
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0); step();
    chk("post_rst_we", 32'(rf_we), 0);
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 8, rand_instr(), $urandom, $urandom, $urandom,
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      step();
      if ($urandom_range(0, 49) == 0) do_reset();
    end
`ifdef WB_RETIRE_CNT_EN
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1, ADDI5, 0, k, 0, 0, 0); step();
      if (k == 4) for (int s = 0; s < 3; s++) begin drive(1, ADDI5, 0, 99, 0, 1, 0); step(); end
      if (k == 6) for (int s = 0; s < 2; s++) begin drive(0, 0, 0, 0, 0, 0, 0); step(); end
    end
    drive(0, 0, 0, 0, 0, 0, 0); step();
    chk("cnt10", 32'(retire_cnt), 10);
    for (int k = 0; k < 5; k++) begin drive(1, ADDI5, 0, k, 0, 0, 0); step(); end
    drive(0, 0, 0, 0, 0, 0, 0); step();
    chk("cnt15", 32'(retire_cnt), 15);
    for (int k = 0; k < 2; k++) begin drive(1, ADDI5, 0, k, 0, 0, 0); step(); end
    drive(0, 0, 0, 0, 0, 0, 0); step();
    chk("cnt_wrap", 32'(retire_cnt), 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mw_writeback_stage.md
# mw_writeback_stage

Memory/writeback pipeline register plus writeback datapath of the five-stage MIPS core. It captures the M-stage instruction, ALU result, data-memory word and return address on each clock edge. From the captured values it decodes the writeback controls, extracts and extends sub-word load data, and drives the register-file write port. It also publishes the W-stage destination and value to the hazard/forwarding unit.

## Interface
- RETIRE_CNT_W, 32, width of the retired-instruction counter (only with `WB_RETIRE_CNT_EN`)
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  hold the M/W register contents
- flush_i  in  1  load a bubble into the M/W register
- valid_M  in  1  M-stage instruction is real, not a bubble
- instr_M  in  32  M-stage instruction word
- pc8_M  in  32  M-stage PC+8, the link value
- alu_out_M  in  32  M-stage ALU result; also the load address
- dm_out_M  in  32  raw aligned word from data memory
- valid_W  out  1  W-stage holds a real instruction
- instr_W  out  32  registered instruction, for the W controller and debug
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- fwd_addr_W  out  5  register written by the W instruction; 0 if none
- fwd_data_W  out  32  equal to rf_wdata
- retire_cnt  out  RETIRE_CNT_W  retired-instruction count (only with `WB_RETIRE_CNT_EN`)

## Operation
- The M/W register holds valid, instr, pc8, alu_out and dm_out.
- Register priority on each edge: rst_n low, then flush_i, then stall_i, then normal load.
  - Flush: valid=0, instr=0, other fields 0.
  - Stall: all fields hold.
  - Normal load: all fields take the M-stage inputs.
- Write-enabling instructions:
  - loads: lb, lbu, lh, lhu, lw
  - R-type ALU and shift: add … sltu, all shifts
  - immediate ALU: addi, addiu, andi, ori, xori, slti, sltiu, lui
  - mfhi, mflo, jal, jalr, bltzal
- Destination register:
  - jal, bltzal: 31
  - R-type ALU and shift, mfhi, mflo, jalr: rd
  - other write-enabling instructions: rt
- Write data source:
  - jal, jalr, bltzal: pc8
  - loads: extended memory data
  - all others: alu_out
- Load extension uses address bits a = alu_out[1:0], little-endian:
  - lb: sign-extend dm_out[8a+7:8a]
  - lbu: zero-extend dm_out[8a+7:8a]
  - lh: sign-extend the halfword at a[1]
  - lhu: zero-extend the halfword at a[1]
  - lw: dm_out unchanged
  - For halfword loads, a[0] is ignored; alignment exceptions are detected upstream.
- rf_we = valid_W AND write-enabling instruction AND rf_waddr≠0.
- fwd_addr_W = rf_waddr when rf_we=1, otherwise 0.
- Unknown opcodes produce rf_we=0.

## Timing
- Latency: M inputs sampled at edge N appear on all W outputs after edge N, combinationally from the register.
- The register file writes on edge N+1.
- Reset values: valid_W=0, instr_W=0, rf_we=0, rf_waddr=0, rf_wdata=0, fwd_addr_W=0, fwd_data_W=0, retire_cnt=0.
- Reset asserted mid-instruction discards the W instruction immediately (asynchronous clear); no partial write occurs.
- stall_i and flush_i asserted together: flush wins.
- Under stall, the held instruction keeps rf_we asserted. The repeated write of the same value is legal.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - retire_cnt port exists.
  - The counter increments on each edge where valid_W=1 and stall_i=0, i.e. the W instruction leaves the stage.
  - It wraps from all-ones to 0 and is cleared by rst_n.
- `WB_RETIRE_CNT_EN` undefined: the port and the counter logic are absent; all other behaviour is identical.

## Structure
- Shared package mips_pkg holds:
  - opcode, funct and REGIMM rt constants
  - field bit ranges: op, rs, rt, rd, shamt, funct, immediate
  - extension-op encoding: word 3'b000, lhu 3'b001, lbu 3'b010, lh 3'b101, lb 3'b110
  - link register index 31
- One sub-module, wb_load_ext: combinational; inputs ext_op, addr[1:0] and the word; output the extended data.
- Decode, pipeline register and counter stay in the top module.

## Test plan
- Reset: assert rst_n=0 mid-stream, then release -> all outputs 0 and rf_we=0 on the first post-reset cycle.
- Sub-word loads: lb at addr 0x...3 with dm_out=0x80FF_1234 -> rf_wdata=0xFFFF_FF80. lbu at the same addr -> 0x0000_0080. lh at addr 0x...2 -> 0xFFFF_80FF. lhu at addr 0x...0 -> 0x0000_1234.
- Link write: jal with pc8_M=0x0000_3008 -> rf_waddr=31, rf_wdata=0x0000_3008. addu $0,$1,$2 -> rf_we=0, fwd_addr_W=0.
- Stall/flush: addi $5 loaded, then stall_i=1 for 3 cycles -> outputs held. Then stall_i=1 and flush_i=1 together -> valid_W=0, rf_we=0 next cycle.
- Counter (macro on): 10 valid instructions, 2 bubbles, 3 stall cycles -> retire_cnt=10. Preload near all-ones and retire 2 -> counter wraps to 1.
